// File: rtl/mem_writeback_pkg.sv
// Shared definitions for the writeback stage: bus widths and FSM state encoding.
package mem_writeback_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned REG_AW = 4;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_LO   = 2'd2,
    WB_HI   = 2'd3
  } wb_state_e;

endpackage

// File: rtl/mem_writeback_half_assembler.sv
// Holds the low half of a split load and emits the full word when the high half arrives.
module half_assembler #(
  parameter int unsigned HALF_W = mem_writeback_pkg::HALF_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                lo_strobe_i,
  input  logic                hi_strobe_i,
  input  logic [HALF_W-1:0]   half_i,
  output logic [2*HALF_W-1:0] word_c
);

  logic [HALF_W-1:0] lo_q;
  logic [HALF_W-1:0] lo_d;

  always_comb begin
    lo_d = lo_q;
    if (lo_strobe_i) begin
      lo_d = half_i;
    end
  end

  // Word is only meaningful while the high half is on the bus.
  always_comb begin
    word_c = '0;
    if (hi_strobe_i) begin
      word_c = {half_i, lo_q};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lo_q <= '0;
    end else begin
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/mem_writeback.sv
// Writeback stage: commits ALU results immediately, or sequences a two-half load
// from data memory before writing the register file and stack pointer.
module mem_writeback #(
  parameter int unsigned DATA_W = mem_writeback_pkg::WORD_W,
  parameter int unsigned HALF_W = mem_writeback_pkg::HALF_W,
  parameter int unsigned REG_AW = mem_writeback_pkg::REG_AW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic              mem_re_i,
  input  logic              mem_to_reg_i,
  input  logic [DATA_W-1:0] data_calc_i,
  input  logic [REG_AW-1:0] rf_wr_select_i,
  input  logic              rf_wr_en_i,
  input  logic [DATA_W-1:0] sp_i,
  input  logic              rf_sp_wr_en_i,
  input  logic [HALF_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rf_wr_data_o,
  output logic [REG_AW-1:0] rf_wr_addr_o,
  output logic              rf_wr_en_o,
  output logic [DATA_W-1:0] rf_sp_data_o,
  output logic              rf_sp_wr_en_o,
  output logic              busy_o,
  output logic              pend_valid_o,
  output logic [REG_AW-1:0] pend_addr_o
);

  import mem_writeback_pkg::*;

  if (DATA_W != 2 * HALF_W || (RD_LAT != 1 && RD_LAT != 2)) begin : g_bad_param
    $error("mem_writeback: DATA_W must be 2*HALF_W and RD_LAT must be 1 or 2");
  end

  wb_state_e state_q, state_d;

  logic              f_m2r_q, f_m2r_d;
  logic [DATA_W-1:0] f_calc_q, f_calc_d;
  logic [REG_AW-1:0] f_addr_q, f_addr_d;
  logic              f_en_q, f_en_d;
  logic [DATA_W-1:0] f_sp_q, f_sp_d;
  logic              f_sp_en_q, f_sp_en_d;

  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic [REG_AW-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic [DATA_W-1:0] rf_sp_data_q, rf_sp_data_d;
  logic              rf_sp_wr_en_q, rf_sp_wr_en_d;
  logic              busy_q, busy_d;
  logic              pend_valid_q, pend_valid_d;
  logic [REG_AW-1:0] pend_addr_q, pend_addr_d;

  logic              accept_c;
  logic              lo_strobe_c;
  logic              hi_strobe_c;
  logic [DATA_W-1:0] word_c;

  half_assembler #(
    .HALF_W (HALF_W)
  ) u_half_assembler (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .lo_strobe_i (lo_strobe_c),
    .hi_strobe_i (hi_strobe_c),
    .half_i      (mem_rdata_i),
    .word_c      (word_c)
  );

  // busy_q still covers the commit cycle, so a valid_i there is also dropped.
  assign accept_c = valid_i && (state_q == WB_IDLE) && !busy_q;

  always_comb begin
    state_d       = state_q;
    f_m2r_d       = f_m2r_q;
    f_calc_d      = f_calc_q;
    f_addr_d      = f_addr_q;
    f_en_d        = f_en_q;
    f_sp_d        = f_sp_q;
    f_sp_en_d     = f_sp_en_q;
    rf_wr_data_d  = rf_wr_data_q;
    rf_wr_addr_d  = rf_wr_addr_q;
    rf_wr_en_d    = 1'b0;
    rf_sp_data_d  = rf_sp_data_q;
    rf_sp_wr_en_d = 1'b0;
    busy_d        = 1'b0;
    pend_valid_d  = 1'b0;
    pend_addr_d   = pend_addr_q;
    lo_strobe_c   = 1'b0;
    hi_strobe_c   = 1'b0;

    unique case (state_q)
      WB_IDLE: begin
        if (accept_c) begin
          f_m2r_d   = mem_to_reg_i;
          f_calc_d  = data_calc_i;
          f_addr_d  = rf_wr_select_i;
          f_en_d    = rf_wr_en_i;
          f_sp_d    = sp_i;
          f_sp_en_d = rf_sp_wr_en_i;
          if (mem_re_i) begin
            state_d      = (RD_LAT == 1) ? WB_LO : WB_WAIT;
            busy_d       = 1'b1;
            pend_valid_d = rf_wr_en_i && mem_to_reg_i;
            pend_addr_d  = rf_wr_select_i;
          end else begin
            rf_wr_en_d    = rf_wr_en_i;
            rf_wr_data_d  = data_calc_i;
            rf_wr_addr_d  = rf_wr_select_i;
            rf_sp_wr_en_d = rf_sp_wr_en_i;
            rf_sp_data_d  = sp_i;
          end
        end
      end
      WB_WAIT: begin
        state_d      = WB_LO;
        busy_d       = 1'b1;
        pend_valid_d = f_en_q && f_m2r_q;
      end
      WB_LO: begin
        lo_strobe_c  = 1'b1;
        state_d      = WB_HI;
        busy_d       = 1'b1;
        pend_valid_d = f_en_q && f_m2r_q;
      end
      WB_HI: begin
        hi_strobe_c   = 1'b1;
        state_d       = WB_IDLE;
        busy_d        = 1'b1;
        pend_valid_d  = f_en_q && f_m2r_q;
        rf_wr_en_d    = f_en_q;
        rf_wr_data_d  = f_m2r_q ? word_c : f_calc_q;
        rf_wr_addr_d  = f_addr_q;
        rf_sp_wr_en_d = f_sp_en_q;
        rf_sp_data_d  = f_sp_q;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= WB_IDLE;
      f_m2r_q       <= 1'b0;
      f_calc_q      <= '0;
      f_addr_q      <= '0;
      f_en_q        <= 1'b0;
      f_sp_q        <= '0;
      f_sp_en_q     <= 1'b0;
      rf_wr_data_q  <= '0;
      rf_wr_addr_q  <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_sp_data_q  <= '0;
      rf_sp_wr_en_q <= 1'b0;
      busy_q        <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      f_m2r_q       <= f_m2r_d;
      f_calc_q      <= f_calc_d;
      f_addr_q      <= f_addr_d;
      f_en_q        <= f_en_d;
      f_sp_q        <= f_sp_d;
      f_sp_en_q     <= f_sp_en_d;
      rf_wr_data_q  <= rf_wr_data_d;
      rf_wr_addr_q  <= rf_wr_addr_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_sp_data_q  <= rf_sp_data_d;
      rf_sp_wr_en_q <= rf_sp_wr_en_d;
      busy_q        <= busy_d;
      pend_valid_q  <= pend_valid_d;
      pend_addr_q   <= pend_addr_d;
    end
  end

  assign rf_wr_data_o  = rf_wr_data_q;
  assign rf_wr_addr_o  = rf_wr_addr_q;
  assign rf_wr_en_o    = rf_wr_en_q;
  assign rf_sp_data_o  = rf_sp_data_q;
  assign rf_sp_wr_en_o = rf_sp_wr_en_q;
  assign busy_o        = busy_q;
  assign pend_valid_o  = pend_valid_q;
  assign pend_addr_o   = pend_addr_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: RD_LAT=1 and RD_LAT=2 instances share the instruction
// inputs; a cycle-level model of the stage contract is compared every cycle.
module tb_mem_writeback;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic              valid_i = 1'b0;
  logic              mem_re_i = 1'b0;
  logic              mem_to_reg_i = 1'b0;
  logic [31:0]       data_calc_i = '0;
  logic [3:0]        rf_wr_select_i = '0;
  logic              rf_wr_en_i = 1'b0;
  logic [31:0]       sp_i = '0;
  logic              rf_sp_wr_en_i = 1'b0;
  logic [1:0][15:0]  rdata = '0;

  logic [1:0][31:0]  o_data;
  logic [1:0][3:0]   o_addr;
  logic [1:0]        o_en;
  logic [1:0][31:0]  o_sp;
  logic [1:0]        o_spen;
  logic [1:0]        o_busy;
  logic [1:0]        o_pend;
  logic [1:0][3:0]   o_paddr;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  mem_writeback #(.RD_LAT(1)) u_dut_l1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .mem_re_i(mem_re_i),
    .mem_to_reg_i(mem_to_reg_i), .data_calc_i(data_calc_i),
    .rf_wr_select_i(rf_wr_select_i), .rf_wr_en_i(rf_wr_en_i), .sp_i(sp_i),
    .rf_sp_wr_en_i(rf_sp_wr_en_i), .mem_rdata_i(rdata[0]),
    .rf_wr_data_o(o_data[0]), .rf_wr_addr_o(o_addr[0]), .rf_wr_en_o(o_en[0]),
    .rf_sp_data_o(o_sp[0]), .rf_sp_wr_en_o(o_spen[0]), .busy_o(o_busy[0]),
    .pend_valid_o(o_pend[0]), .pend_addr_o(o_paddr[0])
  );

  mem_writeback #(.RD_LAT(2)) u_dut_l2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .mem_re_i(mem_re_i),
    .mem_to_reg_i(mem_to_reg_i), .data_calc_i(data_calc_i),
    .rf_wr_select_i(rf_wr_select_i), .rf_wr_en_i(rf_wr_en_i), .sp_i(sp_i),
    .rf_sp_wr_en_i(rf_sp_wr_en_i), .mem_rdata_i(rdata[1]),
    .rf_wr_data_o(o_data[1]), .rf_wr_addr_o(o_addr[1]), .rf_wr_en_o(o_en[1]),
    .rf_sp_data_o(o_sp[1]), .rf_sp_wr_en_o(o_spen[1]), .busy_o(o_busy[1]),
    .pend_valid_o(o_pend[1]), .pend_addr_o(o_paddr[1])
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: a load accepted at end of cycle T sees its low half in cycle T+L,
  // its high half in T+L+1, commits in T+L+2 and is busy for T+1..T+L+2.
  int          cyc;
  bit          have   [2];
  int          ld_t   [2];
  logic [15:0] lo_h   [2];
  logic [15:0] hi_h   [2];
  logic [31:0] f_calc [2];
  logic [31:0] f_sp   [2];
  logic [3:0]  f_addr [2];
  bit          f_en   [2];
  bit          f_m2r  [2];
  bit          f_spen [2];
  logic [31:0] e_data [2];
  logic [3:0]  e_addr [2];
  bit          e_en   [2];
  logic [31:0] e_sp   [2];
  bit          e_spen [2];
  bit          e_busy [2];
  bit          e_pend [2];
  logic [3:0]  e_paddr[2];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      have[k] = 0; ld_t[k] = 0; lo_h[k] = '0; hi_h[k] = '0;
      f_calc[k] = '0; f_sp[k] = '0; f_addr[k] = '0;
      f_en[k] = 0; f_m2r[k] = 0; f_spen[k] = 0;
      e_data[k] = '0; e_addr[k] = '0; e_en[k] = 0; e_sp[k] = '0;
      e_spen[k] = 0; e_busy[k] = 0; e_pend[k] = 0; e_paddr[k] = '0;
    end
  endtask

  initial begin
    int prev;
    int lat;
    bit busy_prev;
    cyc = 0;
    model_clear();
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        model_clear();
      end else begin
        prev = cyc;
        cyc++;
        for (int k = 0; k < 2; k++) begin
          lat = k + 1;
          busy_prev = have[k] && prev >= ld_t[k] + 1 && prev <= ld_t[k] + lat + 2;
          e_en[k] = 0;
          e_spen[k] = 0;
          if (have[k] && prev == ld_t[k] + lat) lo_h[k] = rdata[k];
          if (have[k] && prev == ld_t[k] + lat + 1) hi_h[k] = rdata[k];
          if (have[k] && cyc == ld_t[k] + lat + 2) begin
            e_en[k] = f_en[k];
            e_data[k] = f_m2r[k] ? {hi_h[k], lo_h[k]} : f_calc[k];
            e_addr[k] = f_addr[k];
            e_spen[k] = f_spen[k];
            e_sp[k] = f_sp[k];
          end
          if (valid_i && !busy_prev) begin
            if (mem_re_i) begin
              have[k] = 1; ld_t[k] = prev;
              f_calc[k] = data_calc_i; f_sp[k] = sp_i; f_addr[k] = rf_wr_select_i;
              f_en[k] = rf_wr_en_i; f_m2r[k] = mem_to_reg_i; f_spen[k] = rf_sp_wr_en_i;
              e_paddr[k] = rf_wr_select_i;
            end else begin
              e_en[k] = rf_wr_en_i; e_data[k] = data_calc_i; e_addr[k] = rf_wr_select_i;
              e_spen[k] = rf_sp_wr_en_i; e_sp[k] = sp_i;
            end
          end
          e_busy[k] = have[k] && cyc >= ld_t[k] + 1 && cyc <= ld_t[k] + lat + 2;
          e_pend[k] = e_busy[k] && f_en[k] && f_m2r[k];
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk_i);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("L%0d rf_wr_en", k + 1), 32'(o_en[k]), 32'(e_en[k]));
        check($sformatf("L%0d rf_wr_data", k + 1), o_data[k], e_data[k]);
        check($sformatf("L%0d rf_wr_addr", k + 1), 32'(o_addr[k]), 32'(e_addr[k]));
        check($sformatf("L%0d sp_wr_en", k + 1), 32'(o_spen[k]), 32'(e_spen[k]));
        check($sformatf("L%0d sp_data", k + 1), o_sp[k], e_sp[k]);
        check($sformatf("L%0d busy", k + 1), 32'(o_busy[k]), 32'(e_busy[k]));
        check($sformatf("L%0d pend_valid", k + 1), 32'(o_pend[k]), 32'(e_pend[k]));
        check($sformatf("L%0d pend_addr", k + 1), 32'(o_paddr[k]), 32'(e_paddr[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alu(input logic [3:0] sel, input logic [31:0] calc, input bit en,
                     input bit m2r, input bit spen, input logic [31:0] sp);
    valid_i = 1'b1; mem_re_i = 1'b0; mem_to_reg_i = m2r; data_calc_i = calc;
    rf_wr_select_i = sel; rf_wr_en_i = en; rf_sp_wr_en_i = spen; sp_i = sp;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic load(input logic [3:0] sel, input logic [31:0] calc, input bit en,
                      input bit m2r, input bit spen, input logic [31:0] sp,
                      input logic [15:0] lo, input logic [15:0] hi,
                      input logic [31:0] exp_word, input bit inject, input bit do_rst);
    valid_i = 1'b1; mem_re_i = 1'b1; mem_to_reg_i = m2r; data_calc_i = calc;
    rf_wr_select_i = sel; rf_wr_en_i = en; rf_sp_wr_en_i = spen; sp_i = sp;
    tick();                                      // T+1
    valid_i = 1'b0; mem_re_i = 1'b0; rdata[0] = lo; rdata[1] = '0;
    @(negedge clk_i);
    check("ld T+1 busy L1", 32'(o_busy[0]), 32'd1);
    check("ld T+1 pend_addr L2", 32'(o_paddr[1]), 32'(sel));
    check("ld T+1 pend_valid L1", 32'(o_pend[0]), 32'(en && m2r));
    tick();                                      // T+2
    rdata[0] = hi; rdata[1] = lo;
    if (inject) begin
      valid_i = 1'b1; mem_re_i = 1'b0; data_calc_i = 32'hDEAD_BEEF;
      rf_wr_select_i = 4'hE; rf_wr_en_i = 1'b1;
    end
    if (do_rst) rst_ni = 1'b0;
    @(negedge clk_i);
    check("ld T+2 no early write L1", 32'(o_en[0]), 32'd0);
    tick();                                      // T+3
    valid_i = 1'b0; rdata[0] = '0; rdata[1] = hi;
    @(negedge clk_i);
    if (do_rst) begin
      check("rst mid-load en L1", 32'(o_en[0]), 32'd0);
      check("rst mid-load data L1", o_data[0], 32'd0);
      check("rst mid-load busy L2", 32'(o_busy[1]), 32'd0);
    end else begin
      check("ld commit en L1", 32'(o_en[0]), 32'(en));
      if (en) check("ld commit data L1", o_data[0], exp_word);
      check("ld commit sp_en L1", 32'(o_spen[0]), 32'(spen));
      if (spen) check("ld commit sp L1", o_sp[0], sp);
      check("ld L2 not yet written", 32'(o_en[1]), 32'd0);
      check("ld commit busy L1", 32'(o_busy[0]), 32'd1);
    end
    tick();                                      // T+4
    rdata[1] = '0;
    @(negedge clk_i);
    if (!do_rst) begin
      check("ld commit en L2", 32'(o_en[1]), 32'(en));
      if (en) check("ld commit data L2", o_data[1], exp_word);
      check("ld done busy L1", 32'(o_busy[0]), 32'd0);
    end
    tick();                                      // T+5
    if (do_rst) rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset rf_wr_data", o_data[0], 32'd0);
    check("reset busy", 32'(o_busy[1]), 32'd0);
    check("reset pend_valid", 32'(o_pend[0]), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    alu(4'd3, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("alu en", 32'(o_en[0]), 32'd1);
    check("alu addr", 32'(o_addr[0]), 32'd3);
    check("alu data", o_data[0], 32'h0000_00FF);
    check("alu busy", 32'(o_busy[0]), 32'd0);

    alu(4'd7, 32'h1111_2222, 1'b1, 1'b0, 1'b0, 32'h0);
    alu(4'd8, 32'h3333_4444, 1'b1, 1'b0, 1'b1, 32'h0000_8000);
    @(negedge clk_i);
    check("b2b data", o_data[1], 32'h3333_4444);
    check("b2b sp", o_sp[1], 32'h0000_8000);

    alu(4'd0, 32'h5555_6666, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk_i);
    check("m2r alu data", o_data[0], 32'h5555_6666);
    alu(4'd15, 32'h7777_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("alu en=0", 32'(o_en[0]), 32'd0);
    tick();

    load(4'd5, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 16'h1234, 16'hABCD, 32'hABCD_1234, 1'b0, 1'b0);
    load(4'd6, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 16'h5A5A, 16'h0F0F, 32'h0F0F_5A5A, 1'b1, 1'b0);
    load(4'd9, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 16'h1111, 16'h2222, 32'h2222_1111, 1'b0, 1'b0);
    load(4'd2, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_1004, 16'hBEEF, 16'hCAFE, 32'hCAFE_BEEF, 1'b0, 1'b0);
    load(4'd4, 32'h7777_8888, 1'b1, 1'b0, 1'b0, 32'h0, 16'h9999, 16'hAAAA, 32'h7777_8888, 1'b0, 1'b0);
    load(4'd1, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 16'h4321, 16'h8765, 32'h8765_4321, 1'b0, 1'b1);

    repeat (2) tick();
    alu(4'd10, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("post-reset alu data", o_data[1], 32'hCAFE_F00D);
    check("post-reset alu en", 32'(o_en[1]), 32'd1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Writeback stage directly downstream of the execute/memory stage.
- Collects the two 16-bit halves returned by data memory for a 32-bit load (low half first, then high half) and assembles them into one word.
- Selects between the assembled load word and the registered ALU result, then drives the register-file write port and the SP write port.
- Publishes pending-load information so decode can detect load-use hazards.

Parameters:
- DATA_W, 32, register/word width.
- HALF_W, 16, data-memory bus width; DATA_W must equal 2*HALF_W.
- REG_AW, 4, register-file address width.
- RD_LAT, 1, cycles from memory address presentation to read data valid; legal values 1 or 2.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  one-cycle strobe per instruction entering writeback (cycle T).
- mem_re_i  in  1  instruction is a load; sampled with valid_i.
- mem_to_reg_i  in  1  write memory data (1) or data_calc_i (0); sampled with valid_i.
- data_calc_i  in  DATA_W  ALU result from execute; sampled with valid_i.
- rf_wr_select_i  in  REG_AW  destination register; sampled with valid_i.
- rf_wr_en_i  in  1  destination write enable; sampled with valid_i.
- sp_i  in  DATA_W  updated stack pointer; sampled with valid_i.
- rf_sp_wr_en_i  in  1  SP write enable; sampled with valid_i.
- mem_rdata_i  in  HALF_W  data-memory read bus.
- rf_wr_data_o  out  DATA_W  register-file write data.
- rf_wr_addr_o  out  REG_AW  register-file write address.
- rf_wr_en_o  out  1  register-file write strobe, one cycle per instruction.
- rf_sp_data_o  out  DATA_W  SP write data.
- rf_sp_wr_en_o  out  1  SP write strobe.
- busy_o  out  1  load in flight; upstream must not assert valid_i.
- pend_valid_o  out  1  a load to pend_addr_o is in flight and not yet written.
- pend_addr_o  out  REG_AW  destination of the in-flight load.

Behaviour:
- Reset (async assert, sync release):
  - State WB_IDLE.
  - All outputs 0; capture registers cleared.
  - A load in progress is abandoned; no write occurs.
- States: WB_IDLE, WB_WAIT, WB_LO, WB_HI.
- WB_IDLE, valid_i=1, mem_re_i=0:
  - Register the instruction fields.
  - At T+1: rf_wr_en_o=rf_wr_en_i, rf_wr_data_o=data_calc_i, rf_sp_wr_en_o=rf_sp_wr_en_i, rf_sp_data_o=sp_i.
  - Remain in WB_IDLE, so back-to-back ALU ops write every cycle.
- WB_IDLE, valid_i=1, mem_re_i=1:
  - Latch the fields; busy_o=1 from T+1.
  - Next state is WB_LO if RD_LAT=1, otherwise WB_WAIT.
  - Low address is on the bus at T; high address at T+1.
- WB_WAIT: single dead cycle; next state WB_LO.
- WB_LO: capture mem_rdata_i into lo_q; next state WB_HI.
- WB_HI:
  - Word = {mem_rdata_i, lo_q}.
  - Next cycle: rf_wr_data_o = word if mem_to_reg latched, else data_calc latched.
  - rf_wr_en_o and rf_sp_wr_en_o take their latched values; return to WB_IDLE; busy_o drops.
- Load timing: commit at T+3 for RD_LAT=1, T+4 for RD_LAT=2.
- Byte order: low half first; no sign or zero extension.
- Write strobes are single-cycle; otherwise data outputs hold their last value.
- pend_valid_o is 1 from T+1 until the commit cycle inclusive, only when the latched rf_wr_en and mem_to_reg are both 1.
- valid_i while busy_o=1 is a protocol error: ignored, with no effect on state or outputs.
- mem_to_reg_i=1 with mem_re_i=0: treated as an ALU write using data_calc_i.
- Load with rf_wr_en_i=0: the full sequence still runs (timing preserved), but there is no RF write.
- SP and RF writes in the same cycle are both permitted and independent.
- rf_wr_select_i = 0 or 15 gets no special treatment; the register file owns aliasing.

Decomposition:
- Shared cpu package holds:
  - wb_state_e enum.
  - WORD_W=32, HALF_W=16, REG_AW=4 constants.
- One sub-module, half_assembler: holds lo_q and emits the assembled word on a hi-strobe.
- The FSM and output registers stay in mem_writeback.

Test Plan:
- ALU op: valid_i with data_calc_i=0x0000_00FF, sel=3, en=1 -> cycle T+1: rf_wr_en_o=1, addr=3, data=0x0000_00FF; busy_o stays 0.
- Load, RD_LAT=1: mem_rdata_i=0x1234 at T+1, 0xABCD at T+2 -> T+3: rf_wr_data_o=0xABCD1234, rf_wr_en_o=1; busy_o=1 for T+1..T+3; pend_addr_o = destination.
- Load, RD_LAT=2: halves at T+2/T+3 -> write 0xABCD1234 at T+4; nothing written earlier.
- valid_i pulsed at T+2 during a load with data_calc_i=0xDEAD_BEEF -> ignored; only the load write occurs.
- rst_ni low at T+2 of a load -> all outputs 0 immediately; no write after release; next ALU op writes normally.
- Pop-style load with rf_sp_wr_en_i=1, sp_i=0x0000_1004 -> at commit both strobes high: SP=0x0000_1004, RF gets the assembled word.
